// File: rtl/io_pkg.sv
// Shared constants and types for the memory-mapped I/O responder.
package io_pkg;

  localparam logic [2:0] IO_SEL_DATA   = 3'd0;
  localparam logic [2:0] IO_SEL_STAT   = 3'd1;
  localparam logic [2:0] IO_SEL_FINISH = 3'd4;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    DONE
  } io_state_t;

endpackage

// File: rtl/io_tx_fifo.sv
// Parameterised synchronous FIFO with occupancy count; the head is shown from registered storage.
module io_tx_fifo #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [DW-1:0] i_data,
  output logic [DW-1:0] o_data,
  output logic [AW:0]   o_count,
  output logic          o_empty
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  // A push into a full FIFO is dropped even if a pop happens in the same cycle.
  assign w_do_push = i_push & (r_count != CNT_FULL);
  assign w_do_pop  = i_pop & (r_count != '0);

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/io_responder.sv
// I/O window responder: TX FIFO toward the UART, RX holding register, and the
// termination state machine that waits for pending output to drain.
module io_responder
  import io_pkg::*;
#(
  parameter int unsigned RAM_ADDR_WIDTH = 17,
  parameter int unsigned FIFO_AW        = 4
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       en_in,
  input  logic       wr_in,
  input  logic [2:0] sel_in,
  input  logic [7:0] d_in,
  output logic [7:0] d_out,
  output logic       io_full_out,
  output logic [7:0] tx_data_out,
  output logic       tx_valid_out,
  input  logic       tx_ready_in,
  input  logic [7:0] rx_data_in,
  input  logic       rx_valid_in,
  output logic       rx_ready_out,
  output logic       program_finish_out,
  output logic       overflow_out
);

  localparam int unsigned      DEPTH      = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] CNT_FULL   = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0] CNT_ALMOST = (FIFO_AW + 1)'(DEPTH - 2);

  io_state_t        r_state;
  io_state_t        w_state_next;
  logic [FIFO_AW:0] w_count;
  logic             w_empty;
  logic [7:0]       w_head;
  logic             w_wr;
  logic             w_rd;
  logic             w_push;
  logic             w_pop;
  logic             w_finish_req;
  logic             w_rx_load;
  logic             w_rx_take;
  logic             w_io_full;
  logic [7:0]       w_rd_data;
  logic [7:0]       r_d;
  logic [7:0]       r_rx_data;
  logic             r_rx_held;
  logic             r_overflow;
  logic             w_unused_ram_aw;

  // The RAM window width only matters to the upstream decoder.
  assign w_unused_ram_aw = (RAM_ADDR_WIDTH != 0);

  assign w_wr         = en_in & wr_in;
  assign w_rd         = en_in & ~wr_in;
  assign w_push       = w_wr & (sel_in == IO_SEL_DATA) & (r_state == RUN);
  assign w_pop        = ~w_empty & tx_ready_in;
  assign w_finish_req = w_wr & (sel_in == IO_SEL_FINISH);
  assign w_rx_load    = rx_valid_in & ~r_rx_held;
  assign w_rx_take    = w_rd & (sel_in == IO_SEL_DATA) & r_rx_held;
  assign w_io_full    = (w_count >= CNT_ALMOST);

  io_tx_fifo #(
    .DW(8),
    .AW(FIFO_AW)
  ) u_tx_fifo (
    .i_clk   (clk_in),
    .i_rst_n (rst_n_in),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (d_in),
    .o_data  (w_head),
    .o_count (w_count),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      RUN:     if (w_finish_req) w_state_next = DRAIN;
      DRAIN:   if (w_count == '0) w_state_next = DONE;
      DONE:    w_state_next = DONE;
      default: w_state_next = RUN;
    endcase
  end

  always_comb begin
    w_rd_data = 8'h00;
    case (sel_in)
      IO_SEL_DATA: if (r_rx_held) w_rd_data = r_rx_data;
      IO_SEL_STAT: w_rd_data = {6'b0, r_rx_held, w_io_full};
      default:     w_rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_d        <= 8'h00;
      r_rx_data  <= 8'h00;
      r_rx_held  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_rd) begin
        r_d <= w_rd_data;
      end
      // Load needs an empty register and take needs a full one, so they never collide.
      if (w_rx_load) begin
        r_rx_data <= rx_data_in;
        r_rx_held <= 1'b1;
      end else if (w_rx_take) begin
        r_rx_held <= 1'b0;
      end
      if (w_push && (w_count == CNT_FULL)) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign d_out              = r_d;
  assign io_full_out        = w_io_full;
  assign tx_data_out        = w_head;
  assign tx_valid_out       = ~w_empty;
  assign rx_ready_out       = ~r_rx_held;
  assign program_finish_out = (r_state == DONE);
  assign overflow_out       = r_overflow;

endmodule
